// File: rtl/branch_predict_unit_if.sv
// ---------------------------------------------------------------------------
// | branch_predict_unit_if                                                    |
// | Fetch-lookup and EX-resolve signal bundle for branch_predict_unit.        |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

interface branch_predict_unit_if #(
  parameter int PC_W = 9
);
  logic [PC_W-1:0] F_PC;
  logic            Pred_Taken;
  logic [31:0]     Pred_Target;
  logic [PC_W-1:0] Cur_PC;
  logic [31:0]     Imm;
  logic            Branch;
  logic            JSel;
  logic            JalrSel;
  logic [31:0]     AluResult;
  logic            Ex_Pred_Taken;
  logic [31:0]     Ex_Pred_Target;
  logic            flag_halt;
  logic [31:0]     PC_Imm;
  logic [31:0]     PC_Four;
  logic [31:0]     BrPC;
  logic            PcSel;
  logic            Flush;
  logic [31:0]     Br_Count;
  logic [31:0]     Mispred_Count;

  modport master (
    output F_PC, Cur_PC, Imm, Branch, JSel, JalrSel, AluResult,
           Ex_Pred_Taken, Ex_Pred_Target, flag_halt,
    input  Pred_Taken, Pred_Target, PC_Imm, PC_Four, BrPC, PcSel, Flush,
           Br_Count, Mispred_Count
  );

  modport slave (
    input  F_PC, Cur_PC, Imm, Branch, JSel, JalrSel, AluResult,
           Ex_Pred_Taken, Ex_Pred_Target, flag_halt,
    output Pred_Taken, Pred_Target, PC_Imm, PC_Four, BrPC, PcSel, Flush,
           Br_Count, Mispred_Count
  );
endinterface

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// | branch_predict_unit                                                       |
// | BHT+BTB fetch predictor with EX-stage resolve, redirect and training.     |
// | Optional statistics counters: define BRANCH_STATS_EN.                     |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int BHT_IDX = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  branch_predict_unit_if.slave bus
);
  localparam int TAG_W = PC_W - BHT_IDX - 2;
  localparam int DEPTH = 1 << BHT_IDX;

  localparam logic [1:0] c_CTR_INIT     = 2'b01;
  localparam logic [1:0] c_CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] c_CTR_STRONG_T = 2'b11;
  localparam logic [1:0] c_CTR_STRONG_N = 2'b00;

  logic              r_valid  [DEPTH];
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [31:0]       r_target [DEPTH];
  logic [1:0]        r_ctr    [DEPTH];

  logic [BHT_IDX-1:0] w_f_idx;
  logic [TAG_W-1:0]   w_f_tag;
  logic               w_f_hit;
  logic [BHT_IDX-1:0] w_c_idx;
  logic [TAG_W-1:0]   w_c_tag;
  logic               w_c_hit;
  logic [31:0]        w_cur_pc32;
  logic [31:0]        w_pc_imm;
  logic [31:0]        w_pc_four;
  logic               w_resolve;
  logic               w_actual;
  logic               w_mis_taken;
  logic               w_mis_not_taken;
  logic               w_mispred;
  logic [1:0]         w_ctr_next;
  logic               w_unused_fpc;

  // Fetch lookup reads the registered tables, so a same-cycle train is not visible yet.
  assign w_f_idx         = bus.F_PC[BHT_IDX+1:2];
  assign w_f_tag         = bus.F_PC[PC_W-1:BHT_IDX+2];
  assign w_f_hit         = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign bus.Pred_Taken  = w_f_hit & r_ctr[w_f_idx][1];
  assign bus.Pred_Target = bus.Pred_Taken ? r_target[w_f_idx] : 32'd0;
  assign w_unused_fpc    = ^bus.F_PC[1:0];

  assign w_cur_pc32  = {{(32-PC_W){1'b0}}, bus.Cur_PC};
  assign w_pc_imm    = bus.JalrSel ? {bus.AluResult[31:1], 1'b0} : (w_cur_pc32 + bus.Imm);
  assign w_pc_four   = w_cur_pc32 + 32'd4;
  assign bus.PC_Imm  = w_pc_imm;
  assign bus.PC_Four = w_pc_four;

  assign w_resolve       = (bus.Branch | bus.JSel | bus.JalrSel) & ~bus.flag_halt;
  assign w_actual        = bus.JSel | bus.JalrSel | (bus.Branch & bus.AluResult[0]);
  assign w_mis_taken     = w_actual & (~bus.Ex_Pred_Taken | (bus.Ex_Pred_Target != w_pc_imm));
  assign w_mis_not_taken = ~w_actual & bus.Ex_Pred_Taken;
  assign w_mispred       = w_resolve & (w_mis_taken | w_mis_not_taken);

  assign bus.PcSel = w_mispred;
  assign bus.Flush = w_mispred;
  assign bus.BrPC  = !w_mispred  ? 32'd0 :
                     w_mis_taken ? w_pc_imm : w_pc_four;

  assign w_c_idx = bus.Cur_PC[BHT_IDX+1:2];
  assign w_c_tag = bus.Cur_PC[PC_W-1:BHT_IDX+2];
  assign w_c_hit = r_valid[w_c_idx] && (r_tag[w_c_idx] == w_c_tag);

  // A taken branch that misses in the BTB installs a fresh entry as weakly taken.
  always_comb begin
    w_ctr_next = r_ctr[w_c_idx];
    if (w_actual) begin
      if (!w_c_hit)
        w_ctr_next = c_CTR_WEAK_T;
      else if (r_ctr[w_c_idx] != c_CTR_STRONG_T)
        w_ctr_next = r_ctr[w_c_idx] + 2'd1;
      if (bus.JSel | bus.JalrSel)
        w_ctr_next = c_CTR_STRONG_T;
    end else if (r_ctr[w_c_idx] != c_CTR_STRONG_N) begin
      w_ctr_next = r_ctr[w_c_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= c_CTR_INIT;
      end
    end else if (w_resolve) begin
      r_ctr[w_c_idx] <= w_ctr_next;
      if (w_actual) begin
        r_valid[w_c_idx]  <= 1'b1;
        r_tag[w_c_idx]    <= w_c_tag;
        r_target[w_c_idx] <= w_pc_imm;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_count      <= 32'd0;
      r_mispred_count <= 32'd0;
    end else if (w_resolve) begin
      if (r_br_count != 32'hFFFF_FFFF)
        r_br_count <= r_br_count + 32'd1;
      if (w_mispred && (r_mispred_count != 32'hFFFF_FFFF))
        r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign bus.Br_Count      = r_br_count;
  assign bus.Mispred_Count = r_mispred_count;
`else
  assign bus.Br_Count      = 32'd0;
  assign bus.Mispred_Count = 32'd0;
`endif

endmodule

`default_nettype wire
